// File: rtl/phase_sequencer.sv
// Next-state generator for an external 3-bit state register without reset:
// dwells in each state, then strobes the successor code for one cycle.
module phase_sequencer #(
  parameter int CNT_W  = 8,
  parameter int DWELL0 = 4,
  parameter int DWELL1 = 2,
  parameter int DWELL2 = 3,
  parameter int DWELL3 = 4,
  parameter int DWELL4 = 2,
  parameter int DWELL5 = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cur_state,
  input  logic       req,
  input  logic       hold,
  output logic [2:0] next_state,
  output logic       load,
  output logic       req_pend
);

  typedef enum logic [1:0] {INIT, SETTLE, COUNT, FIRE} fsm_t;

  fsm_t             fsm;
  logic [CNT_W-1:0] cnt;
  logic             illegal;
  logic             at_last;
  logic             leave;

  function automatic logic [CNT_W-1:0] dwell_last(input logic [2:0] s);
    case (s)
      3'd0:    return CNT_W'(DWELL0 - 1);
      3'd1:    return CNT_W'(DWELL1 - 1);
      3'd2:    return CNT_W'(DWELL2 - 1);
      3'd3:    return CNT_W'(DWELL3 - 1);
      3'd4:    return CNT_W'(DWELL4 - 1);
      3'd5:    return CNT_W'(DWELL5 - 1);
      default: return CNT_W'(DWELL0 - 1);
    endcase
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] s);
    case (s)
      3'd0:    return 3'd1;
      3'd1:    return 3'd2;
      3'd2:    return 3'd3;
      3'd3:    return 3'd4;
      3'd4:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  assign illegal = cur_state[2] & cur_state[1];
  assign at_last = (cnt == dwell_last(cur_state));
  // State 000 only advances once a request is pending; others advance freely.
  assign leave   = at_last && !hold && ((cur_state != 3'd0) || req_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= INIT;
      cnt        <= '0;
      load       <= 1'b0;
      next_state <= 3'd0;
      req_pend   <= 1'b0;
    end else begin
      // A new request in the clearing cycle keeps the flag set.
      req_pend <= req | (req_pend & !((fsm == FIRE) && (next_state == 3'd1)));
      load     <= 1'b0;
      case (fsm)
        INIT: begin
          load       <= 1'b1;
          next_state <= 3'd0;
          fsm        <= FIRE;
        end
        FIRE: begin
          cnt <= '0;
          fsm <= SETTLE;
        end
        SETTLE: begin
          cnt <= '0;
          if (illegal) begin
            load       <= 1'b1;
            next_state <= 3'd0;
            fsm        <= FIRE;
          end else begin
            fsm <= COUNT;
          end
        end
        COUNT: begin
          if (!hold) begin
            if (leave) begin
              load       <= 1'b1;
              next_state <= succ(cur_state);
              fsm        <= FIRE;
            end else if (!at_last) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: fsm <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: emulates the external state register and checks
// every cycle against a load-age/dwell reference model.
module tb_phase_sequencer;

  localparam int K_INIT  = 0;
  localparam int K_COUNT = 1;
  localparam int K_ILL   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       hold;
  logic       load;
  logic       req_pend;
  logic [2:0] next_state;
  logic [2:0] sreg;
  logic [2:0] cur_state;
  logic       ill_ovr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int last_load = -1000;
  int gap = 0;

  logic       obs_load, obs_pend, exp_load, exp_pend;
  logic [2:0] obs_ns, exp_ns;
  logic       ill_arm = 1'b0;
  logic       req_on_fire = 1'b0;

  // reference model state
  int         dwell [6] = '{4, 2, 3, 4, 2, 3};
  logic       m_L, m_pend;
  logic [2:0] m_ns, m_reg;
  int         m_kind, m_age, m_runs;

  phase_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cur_state(cur_state), .req(req), .hold(hold),
    .next_state(next_state), .load(load), .req_pend(req_pend)
  );

  always #5 clk = ~clk;

  assign cur_state = ill_ovr ? 3'b111 : sreg;
  always @(posedge clk) if (load) sreg <= next_state;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic model_step(input logic r, input logic h);
    logic       nl, np;
    logic [2:0] nns;
    int         nk;
    nl = 1'b0; nns = 3'd0; nk = m_kind;
    np = r | (m_pend & !(m_L && m_kind == K_COUNT && m_reg == 3'd0));
    if (m_L) begin
      m_age = 0;
      m_reg = m_ns;
    end else begin
      m_age++;
      if (m_age == 1) begin
        m_runs = 0;
        if (m_reg >= 3'd6) begin nl = 1'b1; nns = 3'd0; nk = K_ILL; end
      end else begin
        if (!h) m_runs++;
        if (!h && m_runs >= dwell[m_reg] && (m_reg != 3'd0 || m_pend)) begin
          nl = 1'b1; nns = (m_reg == 3'd5) ? 3'd0 : m_reg + 3'd1; nk = K_COUNT;
        end
      end
    end
    m_L = nl; m_ns = nns; m_kind = nk; m_pend = np;
  endtask

  task automatic step(input logic r, input logic h);
    logic r_eff;
    @(negedge clk);
    cyc++;
    obs_load = load; obs_ns = next_state; obs_pend = req_pend;
    exp_load = m_L;  exp_ns = m_ns;       exp_pend = m_pend;
    if (obs_load === 1'b1) begin gap = cyc - last_load; last_load = cyc; ill_ovr = 1'b0; end
    if (ill_arm && !m_L && m_age == 0) begin ill_ovr = 1'b1; m_reg = 3'b111; ill_arm = 1'b0; end
    r_eff = r | (req_on_fire & m_L & (m_ns == 3'd1));
    req = r_eff; hold = h;
    model_step(r_eff, h);
  endtask

  task automatic reset_on();
    rst_n = 1'b0; req = 1'b0; hold = 1'b0; ill_ovr = 1'b0; ill_arm = 1'b0; req_on_fire = 1'b0;
  endtask

  task automatic reset_release(input int ncyc);
    repeat (ncyc) @(negedge clk);
    rst_n = 1'b1;
    m_L = 1'b1; m_ns = 3'd0; m_kind = K_INIT; m_pend = 1'b0; m_age = 99; m_runs = 0;
    rel_cyc = cyc;
  endtask

  task automatic test_reset();
    reset_on();
    #1;
    n_cmp++;
    if (load !== 1'b0 || next_state !== 3'd0 || req_pend !== 1'b0) begin
      n_err++; $display("FAIL reset_values got load=%b ns=%0d pend=%b want 0/0/0", load, next_state, req_pend);
    end
    reset_release(3);
    step(1'b0, 1'b0);
    n_cmp++;
    if (obs_load !== 1'b1 || obs_ns !== 3'd0 || obs_pend !== 1'b0 || cyc != rel_cyc + 1) begin
      n_err++; $display("FAIL reset_first_load got load=%b ns=%0d pend=%b want 1/0/0", obs_load, obs_ns, obs_pend);
    end
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (obs_load !== exp_load || obs_pend !== exp_pend || (exp_load && obs_ns !== exp_ns)) begin
        n_err++; $display("FAIL reset_model cyc=%0d got load=%b ns=%0d pend=%b want load=%b ns=%0d pend=%b",
                          cyc, obs_load, obs_ns, obs_pend, exp_load, exp_ns, exp_pend);
      end
      n_cmp++;
      if (obs_load !== 1'b0) begin
        n_err++; $display("FAIL reset_idle cyc=%0d got load=%b want 0", cyc, obs_load);
      end
    end
  endtask

  task automatic test_req_sequence();
    int         lc[$];
    logic [2:0] lv[$];
    int         t;
    int         want_gap [6] = '{2, 4, 5, 6, 4, 5};
    logic [2:0] want_ns  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    step(1'b1, 1'b0);
    t = cyc;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (obs_load !== exp_load || obs_pend !== exp_pend || (exp_load && obs_ns !== exp_ns)) begin
        n_err++; $display("FAIL seq_model cyc=%0d got load=%b ns=%0d pend=%b want load=%b ns=%0d pend=%b",
                          cyc, obs_load, obs_ns, obs_pend, exp_load, exp_ns, exp_pend);
      end
      if (obs_load === 1'b1) begin lc.push_back(cyc); lv.push_back(obs_ns); end
    end
    n_cmp++;
    if (lc.size() < 6) begin
      n_err++; $display("FAIL seq_count got %0d loads want at least 6", lc.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
        if ((lc[k] - ((k == 0) ? t : lc[k-1])) != want_gap[k] || lv[k] !== want_ns[k]) begin
          n_err++; $display("FAIL seq_step%0d got gap=%0d ns=%0d want gap=%0d ns=%0d", k,
                            lc[k] - ((k == 0) ? t : lc[k-1]), lv[k], want_gap[k], want_ns[k]);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic found = 1'b0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b0, 1'b0);
      if (obs_load === 1'b1 && obs_ns === 3'd3) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL hold_reach got no load of 3 want load of 3"); end
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step(1'b0, (k >= 2 && k < 5));
      n_cmp++;
      if (obs_load !== exp_load || obs_pend !== exp_pend || (exp_load && obs_ns !== exp_ns)) begin
        n_err++; $display("FAIL hold_model cyc=%0d got load=%b ns=%0d pend=%b want load=%b ns=%0d pend=%b",
                          cyc, obs_load, obs_ns, obs_pend, exp_load, exp_ns, exp_pend);
      end
      if (obs_load === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || gap != 9 || obs_ns !== 3'd4) begin
      n_err++; $display("FAIL hold_interval got gap=%0d ns=%0d want gap=9 ns=4", gap, obs_ns);
    end
  endtask

  task automatic test_illegal();
    logic found = 1'b0;
    int   f = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 1'b0);
      if (obs_load === 1'b1) begin found = 1'b1; f = cyc; end
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL ill_wait got no load want a load"); end
    ill_arm = 1'b1;
    step(1'b0, 1'b0);
    n_cmp++;
    if (obs_load !== 1'b0) begin n_err++; $display("FAIL ill_settle got load=%b want 0", obs_load); end
    step(1'b0, 1'b0);
    n_cmp++;
    if (obs_load !== 1'b1 || obs_ns !== 3'd0 || cyc != f + 2) begin
      n_err++; $display("FAIL ill_recover got load=%b ns=%0d dt=%0d want load=1 ns=0 dt=2", obs_load, obs_ns, cyc - f);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (obs_load !== exp_load || obs_pend !== exp_pend || (exp_load && obs_ns !== exp_ns)) begin
        n_err++; $display("FAIL ill_model cyc=%0d got load=%b ns=%0d pend=%b want load=%b ns=%0d pend=%b",
                          cyc, obs_load, obs_ns, obs_pend, exp_load, exp_ns, exp_pend);
      end
    end
  endtask

  task automatic test_req_in_fire();
    logic found = 1'b0;
    logic seen0 = 1'b0;
    step(1'b1, 1'b0);
    req_on_fire = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0);
      if (obs_load === 1'b1 && obs_ns === 3'd1) found = 1'b1;
    end
    req_on_fire = 1'b0;
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL fire_leave got no load of 1 want load of 1"); end
    step(1'b0, 1'b0);
    n_cmp++;
    if (obs_pend !== 1'b1) begin n_err++; $display("FAIL fire_pend_kept got pend=%b want 1", obs_pend); end
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (obs_load !== exp_load || obs_pend !== exp_pend || (exp_load && obs_ns !== exp_ns)) begin
        n_err++; $display("FAIL fire_model cyc=%0d got load=%b ns=%0d pend=%b want load=%b ns=%0d pend=%b",
                          cyc, obs_load, obs_ns, obs_pend, exp_load, exp_ns, exp_pend);
      end
      if (obs_load === 1'b1 && obs_ns === 3'd0) seen0 = 1'b1;
      else if (obs_load === 1'b1 && obs_ns === 3'd1 && seen0) found = 1'b1;
    end
    n_cmp++;
    if (!found || gap != 6) begin
      n_err++; $display("FAIL fire_auto_advance got found=%b gap=%0d want found=1 gap=6", found, gap);
    end
  endtask

  task automatic test_reset_in_fire();
    logic found = 1'b0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 1'b0);
      if (obs_load === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || obs_pend !== 1'b1) begin
      n_err++; $display("FAIL rstfire_setup got found=%b pend=%b want 1/1", found, obs_pend);
    end
    reset_on();
    #1;
    n_cmp++;
    if (load !== 1'b0 || req_pend !== 1'b0 || next_state !== 3'd0) begin
      n_err++; $display("FAIL rstfire_async got load=%b pend=%b ns=%0d want 0/0/0", load, req_pend, next_state);
    end
    reset_release(2);
    step(1'b0, 1'b0);
    n_cmp++;
    if (obs_load !== 1'b1 || obs_ns !== 3'd0 || obs_pend !== 1'b0 || cyc != rel_cyc + 1) begin
      n_err++; $display("FAIL rstfire_restart got load=%b ns=%0d pend=%b want 1/0/0", obs_load, obs_ns, obs_pend);
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (obs_load !== exp_load || obs_pend !== exp_pend || (exp_load && obs_ns !== exp_ns)) begin
        n_err++; $display("FAIL rstfire_model cyc=%0d got load=%b ns=%0d pend=%b want load=%b ns=%0d pend=%b",
                          cyc, obs_load, obs_ns, obs_pend, exp_load, exp_ns, exp_pend);
      end
    end
  endtask

  task automatic test_random();
    logic prev_load = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 40) == 0) ill_arm = 1'b1;
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
      n_cmp++;
      if (obs_load !== exp_load || obs_pend !== exp_pend || (exp_load && obs_ns !== exp_ns)) begin
        n_err++; $display("FAIL rand_model cyc=%0d got load=%b ns=%0d pend=%b want load=%b ns=%0d pend=%b",
                          cyc, obs_load, obs_ns, obs_pend, exp_load, exp_ns, exp_pend);
      end
      if (prev_load === 1'b1) begin
        n_cmp++;
        if (obs_load !== 1'b0) begin n_err++; $display("FAIL rand_double_load cyc=%0d got load=%b want 0", cyc, obs_load); end
      end
      prev_load = obs_load;
    end
  endtask

  initial begin
    reset_on();
    test_reset();
    test_req_sequence();
    test_hold();
    test_illegal();
    test_req_in_fire();
    test_reset_in_fire();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Next-state generator that drives the 3-bit state register's load inputs. It reads the registered state back, holds each state for a parameterised dwell time, then presents the successor code with a one-cycle load strobe. It also forces the state register to a known code after reset, because the register itself has no reset. The state register's output returns on `cur_state`, and this block's `next_state`/`load` connect to the register's data and enable inputs.

## Interface
Parameters:
- `CNT_W`, 8: dwell counter width.
- `DWELL0`, 4: COUNT cycles spent in state 000 (minimum 1, applies to all DWELLn).
- `DWELL1`, 2: COUNT cycles for state 001.
- `DWELL2`, 3: COUNT cycles for state 010.
- `DWELL3`, 4: COUNT cycles for state 011.
- `DWELL4`, 2: COUNT cycles for state 100.
- `DWELL5`, 3: COUNT cycles for state 101.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `cur_state`  in  3: registered state fed back from the state register.
- `req`  in  1: advance request. Single-cycle pulse or level; latched.
- `hold`  in  1: freezes the dwell counter while high.
- `next_state`  out  3: successor code. Valid only while `load`=1.
- `load`  out  1: one-cycle enable to the state register.
- `req_pend`  out  1: latched request status.

## Operation
- Internal FSM: INIT, SETTLE, COUNT, FIRE. All outputs are registered.
- Reset (async, while `rst_n`=0):
  - FSM goes to INIT; counter=0; `req_pend`=0.
  - `load`=0, `next_state`=000.
- INIT (first cycle after `rst_n` rises): `load`=1, `next_state`=000. Then go to SETTLE.
- SETTLE (one cycle): `load`=0; counter=0. This cycle lets `cur_state` reflect the value just loaded.
  - If `cur_state` is 110 or 111 (illegal), go directly to FIRE with target 000.
  - Otherwise go to COUNT.
- COUNT: counter increments by 1 each cycle that `hold`=0. It holds its value while `hold`=1.
  - Leave COUNT when counter == DWELLs−1, `hold`=0, and either s≠000 or `req_pend`=1.
  - In state 000 with no request, the counter saturates at DWELL0−1 and the block waits.
- FIRE (one cycle): `load`=1 and `next_state`=succ(s). Then go to SETTLE.
  - succ: 000→001→010→011→100→101→000.
- `req_pend`:
  - Set on any cycle with `req`=1.
  - Cleared in the FIRE cycle whose source state is 000.
  - If `req`=1 in that same FIRE cycle, the set wins and `req_pend` stays 1.
- Counter arithmetic: unsigned CNT_W bits, never wraps. DWELLn must be ≤ 2^CNT_W.
- `hold` has no effect in INIT, SETTLE or FIRE.
- `req` is sampled in every state, including INIT.

## Timing
- `load` is never high in two consecutive cycles.
- The state register captures `next_state` on the same edge that ends the `load` cycle.
- Period per state with `hold`=0 and the request already pending: DWELLs+2 cycles, measured load-to-load.
- Latency from reset release: first `load` appears in cycle 1 after `rst_n` rises.
- Latency from state 000 saturated to FIRE: a `req` pulse in cycle t gives `req_pend`=1 at t+1 and FIRE (`load`=1) at t+2.
- Reset mid-operation: all state clears immediately, even during FIRE. `load` drops asynchronously, so no partial load is issued.
- Illegal state recovery: `load` with 000 appears 2 cycles after the illegal value becomes visible (SETTLE, then FIRE).

## Test plan
- Reset release, defaults: `load`=1, `next_state`=000 at cycle 1. `req_pend`=0. No further `load` while `req`=0.
- `req` pulse while in 000: `load` with `next_state`=001 two cycles later. Then loads of 010, 011, 100, 101, 000, spaced 4, 5, 6, 4, 5 cycles apart.
- `hold`=1 for 3 cycles during COUNT in state 011: that load-to-load interval grows from 6 to 9 cycles.
- `cur_state` forced to 111 by the bench after a load: `load` with `next_state`=000 exactly 2 cycles later.
- `req`=1 in the FIRE cycle leaving 000: `req_pend` remains 1, and the next pass through 000 advances after DWELL0 without a new request.
- `rst_n` asserted in a FIRE cycle: `load`=0 immediately, `req_pend`=0. Normal restart sequence follows on release.
